sram_offset_sequencer: RTL and testbench
========================================

// Module: sram_offset_sequencer
//
// PURPOSE
//   Parametrised successor to the two-way SRAM offset select.
//   Arbitrates NUM_CH requesters (cache read-out, stripe counter, parity engine, ...) round-robin.
//   Drives one registered offset stream into the SRAM controller.
//   Two request modes: single-word access, or auto-incrementing burst of req_len words.
//   Offset wraps modulo 2^OFFSET_W.
//
// PARAMETERS
//   OFFSET_W  7  width of SRAM word offset
//   NUM_CH    2  number of requesting channels (>=2)
//   LEN_W     7  width of burst-length field
//
// PORTS
//   clk          in   1                  system clock, all logic on rising edge
//   rst          in   1                  synchronous, active-high reset
//   req_valid    in   NUM_CH             per-channel request pending
//   req_mode     in   NUM_CH             per channel: 0 = single, 1 = burst
//   req_offset   in   NUM_CH*OFFSET_W    start offset; channel i at [i*OFFSET_W +: OFFSET_W]
//   req_len      in   NUM_CH*LEN_W       burst length, same packing; ignored when mode=0
//   req_ready    out  NUM_CH             one-hot, 1-cycle pulse: request of that channel accepted
//   sram_ready   in   1                  SRAM controller consumes the current beat this cycle
//   sram_en      out  1                  current beat valid
//   sram_offset  out  OFFSET_W           offset of current beat
//   sram_ch      out  $clog2(NUM_CH)     channel owning current beat
//   burst_done   out  1                  1-cycle pulse after the last beat is consumed
//   busy         out  1                  state != IDLE
//
// BEHAVIOUR
//   Reset values
//     - All outputs 0; state IDLE; round-robin pointer = 0.
//   States
//     - IDLE:
//       * If any req_valid, grant the first valid channel at or after the pointer, wrapping.
//       * req_ready[g] pulses this cycle; latch offset, len and channel.
//       * Pointer <= g+1 mod NUM_CH; go to ISSUE.
//     - ISSUE:
//       * sram_en=1 with registered offset and channel; offset is presented from the cycle after grant.
//       * sram_ready=0: hold all outputs stable.
//       * sram_ready=1 and beats remain: offset <= offset+1 mod 2^OFFSET_W; remaining--.
//       * sram_ready=1 on the last beat: go to IDLE; burst_done=1 on the next cycle.
//   Latency and ordering
//     - Grant to first beat: 1 cycle.
//     - Last-beat consume to next grant: >=1 cycle. No grant while busy.
//     - req_ready is never asserted while busy.
//   Beat count
//     - mode=0: exactly 1 beat.
//     - mode=1, len=0: 1 beat (len 0 is treated as 1).
//     - mode=1, len=L: L beats.
//   Arithmetic
//     - Offset increment truncates to OFFSET_W; no carry out, no error flag.
//     - Remaining counter is LEN_W bits.
//   Simultaneous requests
//     - Exactly one grant per IDLE cycle; losers stay pending.
//     - Requesters hold req_* until their req_ready.
//   Input stability
//     - Changes to req_* of the owning channel during ISSUE have no effect; values were latched at grant.
//   Reset mid-burst
//     - Next edge: sram_en=0, IDLE, pointer=0; no burst_done pulse.
//
// STRUCTURE
//   Package sram_seq_pkg
//     - typedef enum logic {IDLE, ISSUE} seq_state_t.
//     - CH_W = $clog2(NUM_CH) helper.
//   Sub-module rr_arbiter #(NUM_CH)
//     - Inputs: req vector, pointer, enable.
//     - Outputs: one-hot grant, binary index, any.
//     - Purely combinational.
//   Sequencer holds the FSM, offset and remaining registers, and the pointer.
//
// TESTING
//   1. Single, ch0, offset 0x10, sram_ready=1.
//      -> req_ready[0] at t; sram_en, offset 0x10, ch 0 at t+1; burst_done at t+2.
//   2. Burst, ch1, offset 0x7E, len 4, sram_ready=1.
//      -> offsets 0x7E, 0x7F, 0x00, 0x01 on consecutive cycles (wrap); one burst_done.
//   3. Burst len 3, sram_ready toggling 1,0,0,1,1.
//      -> offset held during stalls; exactly 3 beats consumed; burst_done after the 3rd.
//   4. ch0 and ch1 valid continuously, single mode.
//      -> grants alternate 0,1,0,1; no channel granted twice in a row.
//   5. rst=1 during beat 2 of a len-5 burst.
//      -> next cycle sram_en=0, busy=0, no burst_done; next grant starts from pointer 0.
//   6. mode=1 with len=0.
//      -> exactly one beat; req_ready never asserted while busy (assertion on every cycle).

Source files
------------

// File: rtl/sram_seq_pkg.sv
// Shared types for the SRAM offset sequencer.
// FSM encoding and channel-index width helper.
package sram_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  localparam int OFFSET_W_DEF = 7;
  localparam int NUM_CH_DEF   = 2;
  localparam int LEN_W_DEF    = 7;
  localparam int CH_W         = $clog2(NUM_CH_DEF);

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_offset_sequencer_if.sv
// Request/SRAM bundle between requesters and the sequencer.
// master = requester/controller side, slave = sequencer.
interface sram_offset_sequencer_if
  import sram_seq_pkg::*;
#(
  parameter int OFFSET_W = 7,
  parameter int NUM_CH   = 2,
  parameter int LEN_W    = 7
);
  localparam int CHW = ch_w(NUM_CH);

  logic [NUM_CH-1:0]          req_valid;
  logic [NUM_CH-1:0]          req_mode;
  logic [NUM_CH*OFFSET_W-1:0] req_offset;
  logic [NUM_CH*LEN_W-1:0]    req_len;
  logic [NUM_CH-1:0]          req_ready;
  logic                       sram_ready;
  logic                       sram_en;
  logic [OFFSET_W-1:0]        sram_offset;
  logic [CHW-1:0]             sram_ch;
  logic                       burst_done;
  logic                       busy;

  modport master (
    output req_valid, req_mode, req_offset,
    output req_len, sram_ready,
    input  req_ready, sram_en, sram_offset,
    input  sram_ch, burst_done, busy
  );

  modport slave (
    input  req_valid, req_mode, req_offset,
    input  req_len, sram_ready,
    output req_ready, sram_en, sram_offset,
    output sram_ch, burst_done, busy
  );

endinterface

// File: rtl/sram_offset_sequencer_rr_arbiter.sv
// Combinational round-robin pick: first request
// at or after ptr, wrapping.
module rr_arbiter
  import sram_seq_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CHW    = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [CHW-1:0]    idx,
  output logic              any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    if (en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!any &&
            req[(int'(ptr) + k) % NUM_CH]) begin
          any   = 1'b1;
          grant[(int'(ptr) + k) % NUM_CH] = 1'b1;
          idx   = CHW'((int'(ptr) + k) % NUM_CH);
        end
      end
    end
  end

endmodule

// File: rtl/sram_offset_sequencer.sv
// Round-robin multi-channel SRAM offset sequencer.
// Single-word or auto-incrementing burst streams.
module sram_offset_sequencer
  import sram_seq_pkg::*;
#(
  parameter int OFFSET_W = 7,
  parameter int NUM_CH   = 2,
  parameter int LEN_W    = 7
) (
  input logic clk,
  input logic rst,
  sram_offset_sequencer_if.slave bus
);

  localparam int CHW = ch_w(NUM_CH);

  seq_state_t          state;
  logic [CHW-1:0]      ptr;
  logic [OFFSET_W-1:0] off_q;
  logic [CHW-1:0]      ch_q;
  logic [LEN_W-1:0]    rem;
  logic                done_q;

  logic [NUM_CH-1:0]   grant;
  logic [CHW-1:0]      gidx;
  logic                any;
  logic [OFFSET_W-1:0] sel_off;
  logic [LEN_W-1:0]    sel_len;
  logic                sel_mode;
  logic [LEN_W-1:0]    beats;
  logic [CHW-1:0]      ptr_nxt;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .en    (state == IDLE),
    .grant (grant),
    .idx   (gidx),
    .any   (any)
  );

  always_comb begin
    sel_off  = bus.req_offset[int'(gidx)*OFFSET_W +: OFFSET_W];
    sel_len  = bus.req_len[int'(gidx)*LEN_W +: LEN_W];
    sel_mode = bus.req_mode[gidx];
    // a zero-length burst still moves one word
    beats    = (sel_mode && sel_len != '0) ?
               sel_len : LEN_W'(1);
    ptr_nxt  = (gidx == CHW'(NUM_CH - 1)) ?
               '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      off_q  <= '0;
      ch_q   <= '0;
      rem    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= ISSUE;
            off_q <= sel_off;
            ch_q  <= gidx;
            rem   <= beats;
            ptr   <= ptr_nxt;
          end
        end
        ISSUE: begin
          if (bus.sram_ready) begin
            if (rem == LEN_W'(1)) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              off_q <= off_q + 1'b1;
              rem   <= rem - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = grant;
  assign bus.sram_en     = (state == ISSUE);
  assign bus.busy        = (state == ISSUE);
  assign bus.sram_offset = off_q;
  assign bus.sram_ch     = ch_q;
  assign bus.burst_done  = done_q;

endmodule

// File: tb/tb_sram_offset_sequencer.sv
// Randomized self-checking bench for sram_offset_sequencer.
// Reference: per-grant beat lists plus a round-robin pointer.
module tb_sram_offset_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_offset_sequencer_if #(
    .OFFSET_W(7), .NUM_CH(2), .LEN_W(7)
  ) bus ();

  sram_offset_sequencer #(
    .OFFSET_W(7), .NUM_CH(2), .LEN_W(7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int off;
    int ch;
    bit last;
  } beat_t;

  int total = 0;
  int bad   = 0;
  int ptr_m = 0;

  beat_t q[$];
  int    gseq[$];
  bit    ready_pat[$];
  int    reqs_left [2];
  logic [6:0] offs [2];
  logic [6:0] lens [2];
  bit    modes [2];
  bit    rand_ready = 0;
  bit    lock_mode  = 0;
  int    consumed, dones;

  task automatic drive_req();
    for (int c = 0; c < 2; c++) begin
      bus.req_valid[c]         = (reqs_left[c] > 0);
      bus.req_mode[c]          = modes[c];
      bus.req_offset[c*7 +: 7] = offs[c];
      bus.req_len[c*7 +: 7]    = lens[c];
    end
  endtask

  task automatic set_req(input int c, input bit m,
                         input int o, input int l,
                         input int n);
    modes[c]     = m;
    offs[c]      = 7'(o);
    lens[c]      = 7'(l);
    reqs_left[c] = n;
  endtask

  task automatic serve(input int budget);
    int cyc;
    int g;
    int n;
    bit done_pend;
    bit done_next;
    logic [1:0] er;
    cyc = 0;
    done_pend = 0;
    consumed = 0;
    dones = 0;
    gseq.delete();
    while ((reqs_left[0] > 0 || reqs_left[1] > 0 ||
            q.size() > 0 || done_pend) && cyc < budget) begin
      drive_req();
      if (q.size() > 0 && ready_pat.size() > 0)
        bus.sram_ready = ready_pat.pop_front();
      else if (rand_ready)
        bus.sram_ready = 1'($urandom_range(0, 1));
      else
        bus.sram_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.busy && bus.req_ready != 2'b00) begin
        bad++;
        $display("FAIL ready_while_busy: req_ready=%b busy=%b",
                 bus.req_ready, bus.busy);
      end
      total++;
      if (bus.sram_en !== (q.size() > 0)) begin
        bad++;
        $display("FAIL sram_en: got %b want %b",
                 bus.sram_en, q.size() > 0);
      end
      if (q.size() > 0) begin
        total++;
        if (bus.sram_offset !== 7'(q[0].off) ||
            bus.sram_ch !== 1'(q[0].ch)) begin
          bad++;
          $display("FAIL beat: got off=%h ch=%0d want off=%h ch=%0d",
                   bus.sram_offset, bus.sram_ch, q[0].off, q[0].ch);
        end
      end
      total++;
      if (bus.burst_done !== done_pend) begin
        bad++;
        $display("FAIL burst_done: got %b want %b",
                 bus.burst_done, done_pend);
      end
      if (bus.burst_done === 1'b1) dones++;
      g = -1;
      if (q.size() == 0) begin
        for (int k = 0; k < 2; k++)
          if (g < 0 && reqs_left[(ptr_m + k) % 2] > 0)
            g = (ptr_m + k) % 2;
      end
      er = (g >= 0) ? 2'(1 << g) : 2'b00;
      total++;
      if (bus.req_ready !== er) begin
        bad++;
        $display("FAIL grant: got req_ready=%b want %b",
                 bus.req_ready, er);
      end
      done_next = 0;
      if (q.size() > 0 && bus.sram_ready) begin
        consumed++;
        if (q[0].last) done_next = 1;
        q.delete(0);
      end
      if (g >= 0) begin
        n = (modes[g] && lens[g] != 0) ? int'(lens[g]) : 1;
        for (int i = 0; i < n; i++)
          q.push_back('{(int'(offs[g]) + i) % 128, g, i == n - 1});
        ptr_m = (g + 1) % 2;
        gseq.push_back(g);
        reqs_left[g]--;
      end
      done_pend = done_next;
      @(posedge clk);
      #1;
      if (g >= 0) begin
        // owner scribbles its fields once accepted
        offs[g] = 7'($urandom);
        if (!lock_mode) begin
          lens[g]  = 7'($urandom_range(0, 9));
          modes[g] = 1'($urandom_range(0, 1));
        end
      end
      cyc++;
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL timeout: cycles=%0d budget=%0d", cyc, budget);
    end
  endtask

  task automatic do_reset();
    reqs_left[0] = 0;
    reqs_left[1] = 0;
    drive_req();
    bus.sram_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({bus.sram_en, bus.sram_offset, bus.sram_ch,
         bus.burst_done, bus.busy, bus.req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b off=%h ch=%b done=%b busy=%b rdy=%b want all 0",
               bus.sram_en, bus.sram_offset, bus.sram_ch,
               bus.burst_done, bus.busy, bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    set_req(0, 0, 'h10, 0, 1);
    serve(20);
    total++;
    if (gseq.size() != 1 || gseq[0] != 0 ||
        consumed != 1 || dones != 1) begin
      bad++;
      $display("FAIL single: grants=%0d beats=%0d dones=%0d want 1/1/1",
               gseq.size(), consumed, dones);
    end
  endtask

  task automatic test_burst_wrap();
    set_req(1, 1, 'h7E, 4, 1);
    serve(30);
    total++;
    if (consumed != 4 || dones != 1) begin
      bad++;
      $display("FAIL burst_wrap: beats=%0d dones=%0d want 4/1",
               consumed, dones);
    end
  endtask

  task automatic test_stall();
    ready_pat = '{1, 0, 0, 1, 1};
    set_req(0, 1, $urandom_range(0, 127), 3, 1);
    serve(30);
    total++;
    if (consumed != 3 || dones != 1) begin
      bad++;
      $display("FAIL stall: beats=%0d dones=%0d want 3/1",
               consumed, dones);
    end
    ready_pat.delete();
  endtask

  task automatic test_alternate();
    lock_mode = 1;
    set_req(0, 0, $urandom_range(0, 127), 0, 4);
    set_req(1, 0, $urandom_range(0, 127), 0, 4);
    serve(100);
    lock_mode = 0;
    total++;
    if (gseq.size() != 8) begin
      bad++;
      $display("FAIL alternate_count: got %0d want 8", gseq.size());
    end
    for (int i = 1; i < gseq.size(); i++) begin
      total++;
      if (gseq[i] == gseq[i-1]) begin
        bad++;
        $display("FAIL alternate: grant %0d repeats ch %0d",
                 i, gseq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int o;
    o = $urandom_range(0, 127);
    do_reset();
    set_req(0, 1, o, 5, 1);
    drive_req();
    bus.sram_ready = 1'b1;
    @(posedge clk);
    #1;
    reqs_left[0] = 0;
    drive_req();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.sram_en !== 1'b1 ||
        bus.sram_offset !== 7'((o + 1) % 128)) begin
      bad++;
      $display("FAIL mid_beat2: en=%b off=%h want 1 %h",
               bus.sram_en, bus.sram_offset, 7'((o + 1) % 128));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr_m = 0;
    q.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (bus.sram_en !== 1'b0 || bus.busy !== 1'b0 ||
          bus.burst_done !== 1'b0) begin
        bad++;
        $display("FAIL after_rst: en=%b busy=%b done=%b want 0 0 0",
                 bus.sram_en, bus.busy, bus.burst_done);
      end
      @(posedge clk);
      #1;
    end
    set_req(0, 0, $urandom_range(0, 127), 0, 1);
    set_req(1, 0, $urandom_range(0, 127), 0, 1);
    serve(30);
    total++;
    if (gseq.size() < 1 || gseq[0] != 0) begin
      bad++;
      $display("FAIL rst_pointer: first grant ch %0d want 0",
               gseq.size() > 0 ? gseq[0] : -1);
    end
  endtask

  task automatic test_len_zero();
    set_req(1, 1, $urandom_range(0, 127), 0, 1);
    serve(20);
    total++;
    if (consumed != 1 || dones != 1) begin
      bad++;
      $display("FAIL len_zero: beats=%0d dones=%0d want 1/1",
               consumed, dones);
    end
  endtask

  task automatic test_random();
    rand_ready = 1;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 2; c++)
        set_req(c, 1'($urandom_range(0, 1)),
                $urandom_range(0, 127),
                $urandom_range(0, 9),
                $urandom_range(0, 5));
      serve(3000);
    end
    rand_ready = 0;
  endtask

  initial begin
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_burst_wrap();
    test_stall();
    test_alternate();
    test_reset_mid_burst();
    test_len_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
